// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, with round keys
// fetched by index from an external combinational key store.
module inv_cipher_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic [127:0] pt_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [3:0]  LastKey     = 4'(NR);
  localparam logic [31:0] InvMixCoef  = 32'h0e0b0d09;

  typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_e;

  state_e       st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q, ct_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] core;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = s[(i + 2) % 8] ^ s[(i + 5) % 8] ^ s[(i + 7) % 8];
    end
    return gf_inv(b ^ 8'h05);
  endfunction

  // Byte 0 is bits [127:120]; state is column-major (byte = 4*col + row).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc ^= gmul(InvMixCoef[31 - 8 * ((k - r + 4) % 4) -: 8], s[127 - 8 * (4 * c + k) -: 8]);
        end
        o[127 - 8 * (4 * c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // Shared by ROUND and FINAL; only InvMixColumns differs between them.
  assign core = inv_sub_bytes(inv_shift_rows(state_q));

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    key_idx     = LastKey;
    start_ready = 1'b0;
    unique case (st_q)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid) begin
          ct_d = ct_in;
          st_d = StInit;
        end
      end
      StInit: begin
        state_d = ct_q ^ round_key;
        cnt_d   = LastKey - 4'd1;
        st_d    = StRound;
      end
      StRound: begin
        key_idx = cnt_q;
        state_d = inv_mix_columns(core ^ round_key);
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) st_d = StFinal;
      end
      StFinal: begin
        key_idx     = 4'd0;
        state_d     = core ^ round_key;
        out_valid_d = 1'b1;
        st_d        = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          st_d        = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      state_q     <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (st_q != StIdle);
  assign pt_out    = state_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/inv_cipher_ctrl.md
INV_CIPHER_CTRL -- requirements
Module: inv_cipher_ctrl

Interface
REQ-001 SHALL have parameter: NR, 10, number of AES rounds (only 10 is supported; AES-128).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start_valid  input  1  ciphertext offered.
REQ-005 SHALL have port: start_ready  output  1  block accepts a ciphertext.
REQ-006 SHALL have port: ct_in  input  128  ciphertext; captured on accept.
REQ-007 SHALL have port: key_idx  output  4  round-key index requested from the external key store.
REQ-008 SHALL have port: round_key  input  128  round key for key_idx; combinationally valid in the same cycle.
REQ-009 SHALL have port: pt_out  output  128  plaintext result.
REQ-010 SHALL have port: out_valid  output  1  pt_out valid.
REQ-011 SHALL have port: out_ready  input  1  consumer takes pt_out.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement an iterative AES-128 inverse cipher with one 128-bit state register.
- One inverse round per clock.
- Built from the team's combinational InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns blocks.
REQ-014 SHALL implement FSM states IDLE, INIT, ROUND, FINAL and DONE, encoded in a registered state variable.
REQ-015 In IDLE, SHALL drive start_ready=1 and key_idx=10.
- On start_valid=1, SHALL latch ct_in and go to INIT.
REQ-016 In INIT, SHALL drive key_idx=10 and load state <= ct ^ round_key.
- SHALL set round counter to 9 and go to ROUND.
REQ-017 In ROUND, SHALL drive key_idx=counter and compute state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), round_key)).
- SHALL decrement counter.
- Counter 9 down to 1 gives exactly 9 ROUND cycles.
- SHALL go to FINAL after the counter=1 cycle.
REQ-018 In FINAL, SHALL drive key_idx=0 and compute state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), round_key).
- SHALL go to DONE.
REQ-019 In DONE, SHALL drive out_valid=1 with pt_out=state, both held stable until out_ready=1.
- Then SHALL return to IDLE on that edge.
- DONE->IDLE SHALL NOT accept a new ciphertext in the same cycle.
REQ-020 Latency SHALL be fixed: out_valid rises exactly 11 clock edges after the accepting edge, with no dependence on data.
REQ-021 start_ready SHALL be 0 in all states except IDLE.
- start_valid SHALL be ignored while busy=1.
- The captured ciphertext SHALL NOT change while busy=1.
REQ-022 key_idx SHALL be a pure function of FSM state and counter, with no glitch-causing feedback from round_key.
REQ-023 out_valid SHALL be registered, not combinational from out_ready.
REQ-024 Back-to-back operation: a new ciphertext offered with start_valid held high SHALL be accepted in the first IDLE cycle after the DONE handshake.
- Throughput is therefore 1 block per 13 cycles with out_ready=1.

Reset
REQ-025 rst_n=0 SHALL asynchronously force the following, regardless of current state including mid-round:
- FSM=IDLE, counter=0, state register=0.
- pt_out=0, out_valid=0, busy=0, start_ready=1, key_idx=10.
REQ-026 An operation interrupted by reset SHALL be discarded; no out_valid pulse SHALL follow release.
REQ-027 After rst_n deassertion, the first rising edge SHALL be able to accept a ciphertext.

Verification
REQ-028 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench key-store model supplies round keys; rk10=13111d7fe3944a17f307a78b4d2b30c5), ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt_out 00112233445566778899aabbccddeeff, out_valid 11 edges after accept.
REQ-029 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt_out 3243f6a8885a308d313198a2e0370734.
REQ-030 key_idx trace across one operation -> 10 (INIT), 9,8,...,1 (ROUND), 0 (FINAL), and busy=1 for exactly 12 cycles when out_ready is tied high.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, pt_out stays constant, start_ready stays 0; one cycle with out_ready=1 -> IDLE next edge.
REQ-032 Reset when key_idx=5 -> immediately out_valid=0, pt_out=0, busy=0, start_ready=1; no result appears afterward; next vector (REQ-028) decrypts correctly.
REQ-033 start_valid pulsed with a different ct_in during ROUND -> ignored; result equals the first ciphertext's plaintext; two vectors back-to-back with start_valid held -> both correct, second accepted one cycle after first DONE handshake.
